// File: rtl/alu_arb_pkg.sv
// Shared encodings for the two-requester ALU arbiter: opcodes and FSM states.
package alu_arb_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational N-bit ALU: AND, OR, XOR and ADD with carry-out.
module alu_core
    import alu_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y,
    output logic         carry
);

    logic [N:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        y     = '0;
        carry = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_ADD:  {carry, y} = sum;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, registered response.
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N = 4
`ifdef ALU_ARB_STATS_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_op,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_op,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_data,
    output logic         rsp_carry
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
`endif
);

    state_e       state_reg, state_next;
    logic         last_grant_reg;
    logic         rsp_id_reg;
    logic [N-1:0] rsp_data_reg;
    logic         rsp_carry_reg;

    logic         accept;
    logic         grant;
    logic         grant_valid;
    logic [1:0]   sel_op;
    logic [N-1:0] sel_a;
    logic [N-1:0] sel_b;
    logic [N-1:0] alu_y;
    logic         alu_carry;

    // A held result frees the slot in the same cycle it is consumed.
    assign accept = (state_reg == IDLE) || (rsp_valid && rsp_ready);

    always_comb begin
        grant_valid = accept && (req0_valid || req1_valid);
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_reg;
        end else begin
            grant = req1_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (grant_valid) state_next = RESP;
            RESP: if (rsp_ready && !grant_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid  = (state_reg == RESP);
        req0_ready = grant_valid && (grant == 1'b0);
        req1_ready = grant_valid && (grant == 1'b1);
    end

    assign sel_op = grant ? req1_op : req0_op;
    assign sel_a  = grant ? req1_a  : req0_a;
    assign sel_b  = grant ? req1_b  : req0_b;

    alu_core #(
        .N(N)
    ) u_alu_core (
        .op    (sel_op),
        .a     (sel_a),
        .b     (sel_b),
        .y     (alu_y),
        .carry (alu_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
            rsp_id_reg     <= 1'b0;
            rsp_data_reg   <= '0;
            rsp_carry_reg  <= 1'b0;
        end else if (grant_valid) begin
            last_grant_reg <= grant;
            rsp_id_reg     <= grant;
            rsp_data_reg   <= alu_y;
            rsp_carry_reg  <= alu_carry;
        end
    end

    assign rsp_id    = rsp_id_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_carry = rsp_carry_reg;

`ifdef ALU_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (grant_valid && (grant == (gi == 1)) && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign grant_cnt0 = g_cnt[0].cnt_reg;
    assign grant_cnt1 = g_cnt[1].cnt_reg;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter; one vector per clock cycle.
module tb_alu_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_ready;
    logic [1:0] req0_op;
    logic [3:0] req0_a, req0_b;
    logic       req1_valid, req1_ready;
    logic [1:0] req1_op;
    logic [3:0] req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_carry;
    logic [3:0] rsp_data;
`ifdef ALU_ARB_STATS_EN
    logic [1:0] grant_cnt0, grant_cnt1;
`endif

    int checks = 0;
    int errors = 0;

    alu_arbiter #(
        .N(4)
`ifdef ALU_ARB_STATS_EN
        , .CNT_W(2)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_carry  (rsp_carry)
`ifdef ALU_ARB_STATS_EN
        , .grant_cnt0 (grant_cnt0)
        , .grant_cnt1 (grant_cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v0;
        logic [1:0] op0;
        logic [3:0] a0, b0;
        logic       v1;
        logic [1:0] op1;
        logic [3:0] a1, b1;
        logic       rr;
        logic       e_rdy0, e_rdy1, e_vld, e_id;
        logic [3:0] e_data;
        logic       e_carry;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic vec_t mk(logic v0, logic [1:0] op0, logic [3:0] a0, logic [3:0] b0,
                                logic v1, logic [1:0] op1, logic [3:0] a1, logic [3:0] b1,
                                logic rr, logic e_rdy0, logic e_rdy1, logic e_vld,
                                logic e_id, logic [3:0] e_data, logic e_carry);
        vec_t v;
        v.v0 = v0; v.op0 = op0; v.a0 = a0; v.b0 = b0;
        v.v1 = v1; v.op1 = op1; v.a1 = a1; v.b1 = b1;
        v.rr = rr;
        v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1; v.e_vld = e_vld;
        v.e_id = e_id; v.e_data = e_data; v.e_carry = e_carry;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        req0_valid = v.v0; req0_op = v.op0; req0_a = v.a0; req0_b = v.b0;
        req1_valid = v.v1; req1_op = v.op1; req1_a = v.a1; req1_b = v.b1;
        rsp_ready  = v.rr;
    endtask

    initial begin
        // Columns: v0 op0 a0 b0 | v1 op1 a1 b1 | rsp_ready || rdy0 rdy1 rsp_valid id data carry
        vecs[0]  = mk(1, 2'b00, 4'hF, 4'h5, 0, 2'b00, 4'h0, 4'h0, 1, 1, 0, 0, 0, 4'h0, 0);
        vecs[1]  = mk(1, 2'b10, 4'hF, 4'hA, 1, 2'b01, 4'h0, 4'hF, 1, 0, 1, 1, 0, 4'h5, 0);
        vecs[2]  = mk(1, 2'b10, 4'hF, 4'hA, 1, 2'b01, 4'h0, 4'hF, 1, 1, 0, 1, 1, 4'hF, 0);
        vecs[3]  = mk(1, 2'b10, 4'hF, 4'hA, 1, 2'b01, 4'h0, 4'hF, 1, 0, 1, 1, 0, 4'h5, 0);
        vecs[4]  = mk(0, 2'b00, 4'h0, 4'h0, 1, 2'b11, 4'h7, 4'h9, 1, 0, 1, 1, 1, 4'hF, 0);
        vecs[5]  = mk(0, 2'b00, 4'h0, 4'h0, 0, 2'b00, 4'h0, 4'h0, 1, 0, 0, 1, 1, 4'h0, 1);
        vecs[6]  = mk(1, 2'b00, 4'hF, 4'h5, 0, 2'b00, 4'h0, 4'h0, 0, 1, 0, 0, 1, 4'h0, 1);
        vecs[7]  = mk(1, 2'b10, 4'hF, 4'hA, 0, 2'b00, 4'h0, 4'h0, 0, 0, 0, 1, 0, 4'h5, 0);
        vecs[8]  = mk(1, 2'b10, 4'hF, 4'hA, 0, 2'b00, 4'h0, 4'h0, 0, 0, 0, 1, 0, 4'h5, 0);
        vecs[9]  = mk(1, 2'b10, 4'hF, 4'hA, 0, 2'b00, 4'h0, 4'h0, 0, 0, 0, 1, 0, 4'h5, 0);
        vecs[10] = mk(1, 2'b10, 4'hF, 4'hA, 0, 2'b00, 4'h0, 4'h0, 1, 1, 0, 1, 0, 4'h5, 0);
        vecs[11] = mk(0, 2'b00, 4'h0, 4'h0, 0, 2'b00, 4'h0, 4'h0, 1, 0, 0, 1, 0, 4'h5, 0);
        vecs[12] = mk(0, 2'b00, 4'h0, 4'h0, 1, 2'b11, 4'h3, 4'h4, 0, 0, 1, 0, 0, 4'h5, 0);
        vecs[13] = mk(1, 2'b01, 4'hA, 4'h5, 1, 2'b00, 4'hC, 4'hA, 0, 0, 0, 1, 1, 4'h7, 0);
        vecs[14] = mk(1, 2'b01, 4'hA, 4'h5, 1, 2'b00, 4'hC, 4'hA, 1, 1, 0, 1, 1, 4'h7, 0);
        vecs[15] = mk(1, 2'b01, 4'hA, 4'h5, 1, 2'b00, 4'hC, 4'hA, 1, 0, 1, 1, 0, 4'hF, 0);
        vecs[16] = mk(0, 2'b00, 4'h0, 4'h0, 0, 2'b00, 4'h0, 4'h0, 1, 0, 0, 1, 1, 4'h8, 0);
        vecs[17] = mk(0, 2'b00, 4'h0, 4'h0, 0, 2'b00, 4'h0, 4'h0, 1, 0, 0, 0, 1, 4'h8, 0);

        rst = 1'b1;
        drive(mk(0, 2'b00, 4'h0, 4'h0, 0, 2'b00, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_id",    32'(rsp_id),    32'd0);
        check("reset_rsp_data",  32'(rsp_data),  32'd0);
        check("reset_rsp_carry", 32'(rsp_carry), 32'd0);
`ifdef ALU_ARB_STATS_EN
        check("reset_cnt0", 32'(grant_cnt0), 32'd0);
        check("reset_cnt1", 32'(grant_cnt1), 32'd0);
`endif
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            #2;
            $display("vec %0d: rdy0=%0b rdy1=%0b rsp_valid=%0b id=%0b data=%h carry=%0b",
                     i, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_data, rsp_carry);
            check($sformatf("v%0d_rdy0", i),  32'(req0_ready), 32'(vecs[i].e_rdy0));
            check($sformatf("v%0d_rdy1", i),  32'(req1_ready), 32'(vecs[i].e_rdy1));
            check($sformatf("v%0d_valid", i), 32'(rsp_valid),  32'(vecs[i].e_vld));
            check($sformatf("v%0d_id", i),    32'(rsp_id),     32'(vecs[i].e_id));
            check($sformatf("v%0d_data", i),  32'(rsp_data),   32'(vecs[i].e_data));
            check($sformatf("v%0d_carry", i), 32'(rsp_carry),  32'(vecs[i].e_carry));
            @(negedge clk);
        end

`ifdef ALU_ARB_STATS_EN
        // Five grants each went to req0 and req1; a 2-bit counter saturates at 3.
        check("sat_cnt0", 32'(grant_cnt0), 32'd3);
        check("sat_cnt1", 32'(grant_cnt1), 32'd3);
`endif

        // Reset mid-operation: park a req0 result (last_grant becomes 0), then reset.
        drive(mk(1, 2'b00, 4'hF, 4'h5, 0, 2'b00, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0));
        @(negedge clk);
        drive(mk(0, 2'b00, 4'h0, 4'h0, 0, 2'b00, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 0));
        #2;
        check("pre_rst_valid", 32'(rsp_valid), 32'd1);
        check("pre_rst_data",  32'(rsp_data),  32'd5);
        rst = 1'b1;
        #1;
        $display("async reset: rsp_valid=%0b data=%h", rsp_valid, rsp_data);
        check("async_rst_valid", 32'(rsp_valid), 32'd0);
        check("async_rst_data",  32'(rsp_data),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(mk(1, 2'b01, 4'h3, 4'h4, 1, 2'b10, 4'h3, 4'h4, 1, 0, 0, 0, 0, 4'h0, 0));
        #2;
        $display("post-reset contest: rdy0=%0b rdy1=%0b", req0_ready, req1_ready);
        check("post_rst_rdy0", 32'(req0_ready), 32'd1);
        check("post_rst_rdy1", 32'(req1_ready), 32'd0);
        @(negedge clk);
        drive(mk(0, 2'b00, 4'h0, 4'h0, 0, 2'b00, 4'h0, 4'h0, 1, 0, 0, 0, 0, 4'h0, 0));
        #2;
        $display("post-reset result: valid=%0b id=%0b data=%h", rsp_valid, rsp_id, rsp_data);
        check("post_rst_valid", 32'(rsp_valid), 32'd1);
        check("post_rst_id",    32'(rsp_id),    32'd0);
        check("post_rst_data",  32'(rsp_data),  32'd7);
`ifdef ALU_ARB_STATS_EN
        check("post_rst_cnt0", 32'(grant_cnt0), 32'd1);
        check("post_rst_cnt1", 32'(grant_cnt1), 32'd0);
`endif
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
